// File: rtl/fb_sram_writer_if.sv
// Pixel write channel of the framebuffer writer: a valid/ready request
// carrying (x, y, RGB565), plus the out-of-range drop pulse.
interface fb_sram_writer_if;
    logic        px_valid;
    logic        px_ready;
    logic [9:0]  px_x;
    logic [8:0]  px_y;
    logic [15:0] px_rgb;
    logic        px_drop;

    modport master (output px_valid, px_x, px_y, px_rgb, input px_ready, px_drop);
    modport slave  (input px_valid, px_x, px_y, px_rgb, output px_ready, px_drop);
endinterface

// File: rtl/fb_sram_writer.sv
// Framebuffer write side: buffers pixel writes in a small FIFO, or runs a whole-frame
// fill, and commits words to the external SRAM only while the display has released it.
//
//   state  | meaning
//   IDLE   | bus released, all SRAM pins high-Z
//   SETUP  | address/data driven, CE low, WE high
//   STROBE | WE low for one clock
//   HOLD   | WE high, data still driven; FIFO pops or fill address advances
module fb_sram_writer #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            blank,
    fb_sram_writer_if.slave px,
    input  logic            fill_start,
    input  logic [15:0]     fill_rgb,
    output logic            fill_busy,
    output logic            bus_own,
    output logic [19:0]     SRAM_ADDR,
    inout  wire  [15:0]     SRAM_DQ,
    output logic            SRAM_CE_N,
    output logic            SRAM_OE_N,
    output logic            SRAM_WE_N,
    output logic            SRAM_UB_N,
    output logic            SRAM_LB_N
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          PW        = AW + 1;
    localparam logic [31:0] H_LIM     = 32'(H_RES);
    localparam logic [31:0] V_LIM     = 32'(V_RES);
    localparam logic [19:0] FILL_LAST = 20'(H_RES * V_RES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [35:0]    fifo_mem_q [FIFO_DEPTH];
    logic           src_fifo_q, src_fifo_d;
    logic           fill_busy_q, fill_busy_d;
    logic [19:0]    fill_addr_q, fill_addr_d;
    logic [15:0]    fill_rgb_q, fill_rgb_d;
    logic           drop_q, drop_d;
    logic           bus_own_q, bus_own_d;

    logic           fifo_empty, fifo_full, in_range, push, push_store;
    logic [19:0]    px_addr, wr_addr;
    logic [15:0]    wr_data;
    logic [35:0]    head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign px.px_ready = !fifo_full && !fill_busy_q;
    assign push        = px.px_valid && px.px_ready;
    assign in_range    = (32'(px.px_x) < H_LIM) && (32'(px.px_y) < V_LIM);
    assign px_addr     = 20'(px.px_y) * 20'(H_RES) + 20'(px.px_x);
    assign push_store  = push && in_range;

    assign head    = fifo_mem_q[rd_ptr_q[AW-1:0]];
    assign wr_addr = src_fifo_q ? head[35:16] : fill_addr_q;
    assign wr_data = src_fifo_q ? head[15:0]  : fill_rgb_q;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        src_fifo_d  = src_fifo_q;
        fill_busy_d = fill_busy_q;
        fill_addr_d = fill_addr_q;
        fill_rgb_d  = fill_rgb_q;
        drop_d      = push && !in_range;

        if (push_store) wr_ptr_d = wr_ptr_q + 1'b1;
        if (fill_start && !fill_busy_q) begin
            fill_busy_d = 1'b1;
            fill_addr_d = '0;
            fill_rgb_d  = fill_rgb;
        end

        case (state_q)
            S_IDLE: begin
                if (blank && (!fifo_empty || fill_busy_q)) begin
                    state_d    = S_SETUP;
                    src_fifo_d = !fifo_empty;
                end
            end
            S_SETUP:  state_d = S_STROBE;
            S_STROBE: state_d = S_HOLD;
            S_HOLD: begin
                if (src_fifo_q)                   rd_ptr_d    = rd_ptr_q + 1'b1;
                else if (fill_addr_q == FILL_LAST) fill_busy_d = 1'b0;
                else                              fill_addr_d = fill_addr_q + 20'd1;
                // decide on post-pop occupancy so a word is never written twice
                if (blank && ((wr_ptr_d != rd_ptr_d) || fill_busy_d)) begin
                    state_d    = S_SETUP;
                    src_fifo_d = (wr_ptr_d != rd_ptr_d);
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        bus_own_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            src_fifo_q  <= 1'b0;
            fill_busy_q <= 1'b0;
            fill_addr_q <= '0;
            fill_rgb_q  <= '0;
            drop_q      <= 1'b0;
            bus_own_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            src_fifo_q  <= src_fifo_d;
            fill_busy_q <= fill_busy_d;
            fill_addr_q <= fill_addr_d;
            fill_rgb_q  <= fill_rgb_d;
            drop_q      <= drop_d;
            bus_own_q   <= bus_own_d;
            if (push_store) fifo_mem_q[wr_ptr_q[AW-1:0]] <= {px_addr, px.px_rgb};
        end
    end

    assign fill_busy   = fill_busy_q;
    assign bus_own     = bus_own_q;
    assign px.px_drop  = drop_q;

    assign SRAM_ADDR = bus_own_q ? wr_addr : 'z;
    assign SRAM_DQ   = bus_own_q ? wr_data : 'z;
    assign SRAM_CE_N = bus_own_q ? 1'b0 : 1'bz;
    assign SRAM_OE_N = bus_own_q ? 1'b1 : 1'bz;
    assign SRAM_WE_N = bus_own_q ? (state_q != S_STROBE) : 1'bz;
    assign SRAM_UB_N = bus_own_q ? 1'b0 : 1'bz;
    assign SRAM_LB_N = bus_own_q ? 1'b0 : 1'bz;
endmodule
